// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter slice.
//  - alu_op_e    : 4-bit ALU opcode encodings used by every ALU client.
//  - arb_state_e : arbiter state encoding, exported so that the controller
//                  and debug logic can decode the arbiter state.
//  - is_slow_op  : identifies the multicycle ops (MUL/DIV/MOD).
package alu_arbiter_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_MUL  = 4'd10,
    ALU_DIV  = 4'd11,
    ALU_MOD  = 4'd12
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  // Wide enough for SLOW_CYCLES up to 15.
  localparam int CNT_W = 4;

  function automatic logic is_slow_op(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_DIV) || (op == ALU_MOD);
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Purely combinational ALU shared by the arbiter's two requesters.
// Ports:
//   a_i, b_i : operands (WORD_SIZE bits)
//   op_i     : 4-bit opcode (alu_op_e)
//   y_o      : result (WORD_SIZE bits)
// Division and modulo by zero return 0 here so that no X reaches the
// arbiter; the arbiter substitutes the architectural divide-by-zero values.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int WORD_SIZE = 64
) (
  input  logic [WORD_SIZE-1:0] a_i,
  input  logic [WORD_SIZE-1:0] b_i,
  input  logic [3:0]           op_i,
  output logic [WORD_SIZE-1:0] y_o
);

  localparam int SH_W = $clog2(WORD_SIZE);

  logic [SH_W-1:0] shamt;
  logic            b_is_zero;

  assign shamt     = b_i[SH_W-1:0];
  assign b_is_zero = (b_i == '0);

  always_comb begin
    y_o = '0;
    case (op_i)
      ALU_ADD:  y_o = a_i + b_i;
      ALU_SUB:  y_o = a_i - b_i;
      ALU_AND:  y_o = a_i & b_i;
      ALU_OR:   y_o = a_i | b_i;
      ALU_XOR:  y_o = a_i ^ b_i;
      ALU_SLL:  y_o = a_i << shamt;
      ALU_SRL:  y_o = a_i >> shamt;
      ALU_SRA:  y_o = $unsigned($signed(a_i) >>> shamt);
      ALU_SLT:  y_o = {{(WORD_SIZE-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SLTU: y_o = {{(WORD_SIZE-1){1'b0}}, (a_i < b_i)};
      ALU_MUL:  y_o = a_i * b_i;
      ALU_DIV:  y_o = b_is_zero ? '0 : (a_i / b_i);
      ALU_MOD:  y_o = b_is_zero ? '0 : (a_i % b_i);
      default:  y_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a single shared ALU.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   req_valid/req_ready   : per-requester request handshake (ready is
//                           combinational from req_valid, only in IDLE)
//   req_a, req_b, req_op  : per-requester operands/opcode, requester i in
//                           slice i
//   resp_valid/resp_ready : per-requester response handshake
//   resp_out              : registered result shared by both requesters
//   resp_zero, resp_err   : result-is-zero and divide-by-zero flags
//   busy                  : high while in EXEC or RESP
// SLOW_CYCLES must lie in 1..15 (counter width is CNT_W).
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WORD_SIZE   = 64,
  parameter int SLOW_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [2*WORD_SIZE-1:0] req_a,
  input  logic [2*WORD_SIZE-1:0] req_b,
  input  logic [7:0]             req_op,
  output logic [1:0]             resp_valid,
  input  logic [1:0]             resp_ready,
  output logic [WORD_SIZE-1:0]   resp_out,
  output logic                   resp_zero,
  output logic                   resp_err,
  output logic                   busy
);

  arb_state_e           state_q;
  logic                 gnt_q;
  logic                 last_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [1:0]           resp_valid_q;
  logic [WORD_SIZE-1:0] resp_out_q;
  logic                 resp_zero_q;
  logic                 resp_err_q;
  logic                 busy_q;

  // Operand registers hold the ALU inputs for the whole EXEC phase.
  logic [WORD_SIZE-1:0] a_q;
  logic [WORD_SIZE-1:0] b_q;
  logic [3:0]           op_q;

  logic                 gnt_d;
  logic                 req_hs;
  logic [WORD_SIZE-1:0] a_sel;
  logic [WORD_SIZE-1:0] b_sel;
  logic [3:0]           op_sel;
  logic [WORD_SIZE-1:0] alu_y;
  logic                 div_zero;
  logic [WORD_SIZE-1:0] result_d;

  // Round-robin: a lone requester always wins; on a tie, the one not
  // served last wins.
  always_comb begin
    gnt_d = 1'b0;
    case (req_valid)
      2'b01:   gnt_d = 1'b0;
      2'b10:   gnt_d = 1'b1;
      2'b11:   gnt_d = ~last_q;
      default: gnt_d = 1'b0;
    endcase
  end

  assign req_hs = (state_q == ST_IDLE) && (|req_valid);

  // Gated with reset_n so that req_ready is 0 while reset is asserted,
  // even though the FSM sits in IDLE.
  assign req_ready = (req_hs && reset_n) ? {gnt_d, ~gnt_d} : 2'b00;

  assign a_sel  = gnt_d ? req_a[2*WORD_SIZE-1:WORD_SIZE] : req_a[WORD_SIZE-1:0];
  assign b_sel  = gnt_d ? req_b[2*WORD_SIZE-1:WORD_SIZE] : req_b[WORD_SIZE-1:0];
  assign op_sel = gnt_d ? req_op[7:4] : req_op[3:0];

  always_ff @(posedge clk) begin
    if (req_hs) begin
      a_q  <= a_sel;
      b_q  <= b_sel;
      op_q <= op_sel;
    end
  end

  alu_arbiter_alu #(
    .WORD_SIZE (WORD_SIZE)
  ) u_alu (
    .a_i  (a_q),
    .b_i  (b_q),
    .op_i (op_q),
    .y_o  (alu_y)
  );

  // Architectural divide-by-zero results: DIV -> all ones, MOD -> dividend.
  always_comb begin
    div_zero = (b_q == '0) && ((op_q == ALU_DIV) || (op_q == ALU_MOD));
    result_d = alu_y;
    if (div_zero) begin
      result_d = (op_q == ALU_DIV) ? '1 : a_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      gnt_q        <= 1'b0;
      last_q       <= 1'b1;
      cnt_q        <= '0;
      resp_valid_q <= 2'b00;
      resp_out_q   <= '0;
      resp_zero_q  <= 1'b0;
      resp_err_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_hs) begin
            gnt_q   <= gnt_d;
            last_q  <= gnt_d;
            cnt_q   <= is_slow_op(op_sel) ? CNT_W'(SLOW_CYCLES) : CNT_W'(1);
            busy_q  <= 1'b1;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt_q == CNT_W'(1)) begin
            resp_out_q   <= result_d;
            resp_zero_q  <= (result_d == '0);
            resp_err_q   <= div_zero;
            resp_valid_q <= {gnt_q, ~gnt_q};
            state_q      <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_RESP: begin
          // Only the granted requester's resp_ready matters.
          if (resp_ready[gnt_q]) begin
            resp_valid_q <= 2'b00;
            busy_q       <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          resp_valid_q <= 2'b00;
          busy_q       <= 1'b0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_out   = resp_out_q;
  assign resp_zero  = resp_zero_q;
  assign resp_err   = resp_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int W = 64;

  logic           clk;
  logic           reset_n;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [2*W-1:0] req_a;
  logic [2*W-1:0] req_b;
  logic [7:0]     req_op;
  logic [1:0]     resp_valid;
  logic [1:0]     resp_ready;
  logic [W-1:0]   resp_out;
  logic           resp_zero;
  logic           resp_err;
  logic           busy;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(
    .WORD_SIZE   (W),
    .SLOW_CYCLES (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_out   (resp_out),
    .resp_zero  (resp_zero),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic [3:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[idx*W +: W] = a;
    req_b[idx*W +: W] = b;
    req_op[idx*4 +: 4] = op;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"},  W'(req_ready),  '0);
    chk({tag, "_resp_valid"}, W'(resp_valid), '0);
    chk({tag, "_resp_out"},   resp_out,       '0);
    chk({tag, "_resp_zero"},  W'(resp_zero),  '0);
    chk({tag, "_resp_err"},   W'(resp_err),   '0);
    chk({tag, "_busy"},       W'(busy),       '0);
  endtask

  // Issue one request from requester idx when idle, check req_ready in the
  // handshake cycle T, check resp_valid stays low until T+lat, then check
  // the response and complete it.
  task automatic run_op(input string tag, input int idx, input logic [3:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b, input int lat,
                        input logic [W-1:0] exp_out, input logic exp_zero, input logic exp_err);
    logic [1:0] onehot;
    onehot = (idx == 0) ? 2'b01 : 2'b10;
    set_req(idx, op, a, b);
    req_valid[idx] = 1'b1;
    #1;
    chk({tag, "_req_ready"}, W'(req_ready), W'(onehot));
    tick();
    req_valid[idx] = 1'b0;
    for (int k = 1; k < lat; k++) begin
      chk({tag, "_early_valid"}, W'(resp_valid), '0);
      tick();
    end
    chk({tag, "_resp_valid"}, W'(resp_valid), W'(onehot));
    chk({tag, "_resp_out"},   resp_out,       exp_out);
    chk({tag, "_resp_zero"},  W'(resp_zero),  W'(exp_zero));
    chk({tag, "_resp_err"},   W'(resp_err),   W'(exp_err));
    resp_ready[idx] = 1'b1;
    tick();
    resp_ready = 2'b00;
    chk({tag, "_valid_drop"}, W'(resp_valid), '0);
    chk({tag, "_busy_drop"},  W'(busy),       '0);
  endtask

  initial begin
    reset_n    = 1'b0;
    req_valid  = 2'b00;
    req_a      = '0;
    req_b      = '0;
    req_op     = '0;
    resp_ready = 2'b00;

    // Reset state, including req_ready held low while requests are present.
    tick();
    tick();
    chk_reset_outputs("reset");
    req_valid = 2'b11;
    #1;
    chk("reset_req_ready_gated", W'(req_ready), '0);
    req_valid = 2'b00;
    tick();
    reset_n = 1'b1;
    tick();

    // Single fast op and a slow op.
    run_op("add",  0, ALU_ADD, 64'd5,   64'd7, 2, 64'd12, 1'b0, 1'b0);
    run_op("div",  1, ALU_DIV, 64'd100, 64'd7, 5, 64'd14, 1'b0, 1'b0);
    run_op("mul",  0, ALU_MUL, 64'd6,   64'd7, 5, 64'd42, 1'b0, 1'b0);

    // Divide-by-zero.
    run_op("div0", 1, ALU_DIV, 64'd9, 64'd0, 5, {W{1'b1}}, 1'b0, 1'b1);
    run_op("mod0", 0, ALU_MOD, 64'd9, 64'd0, 5, 64'd9,     1'b0, 1'b1);

    // Contention out of reset: both valid all the time, grants alternate 0,1,0,1.
    reset_n = 1'b0;
    set_req(0, ALU_SUB, 64'd3, 64'd3);
    set_req(1, ALU_SUB, 64'd3, 64'd3);
    req_valid = 2'b11;
    tick();
    tick();
    reset_n    = 1'b1;
    resp_ready = 2'b11;
    #1;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] exp_g;
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      chk("rr_req_ready", W'(req_ready), W'(exp_g));
      tick();
      tick();
      chk("rr_resp_valid", W'(resp_valid), W'(exp_g));
      chk("rr_resp_out",   resp_out,       '0);
      chk("rr_resp_zero",  W'(resp_zero),  64'd1);
      tick();
    end
    req_valid  = 2'b00;
    resp_ready = 2'b00;
    tick();

    // Backpressure: response held for 10 cycles, wrong requester's ready ignored.
    set_req(0, ALU_ADD, 64'd10, 64'd20);
    req_valid = 2'b01;
    #1;
    chk("bp_req_ready0", W'(req_ready), 64'd1);
    tick();
    set_req(1, ALU_XOR, 64'hF0, 64'h0F);
    req_valid = 2'b10;
    chk("bp_exec_no_ready", W'(req_ready), '0);
    tick();
    resp_ready = 2'b10;
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold_valid", W'(resp_valid), 64'd1);
      chk("bp_hold_out",   resp_out,       64'd30);
      chk("bp_no_grant",   W'(req_ready),  '0);
      tick();
    end
    resp_ready = 2'b01;
    #1;
    chk("bp_ready_rise_no_grant", W'(req_ready), '0);
    tick();
    resp_ready = 2'b00;
    chk("bp_next_grant", W'(req_ready),  64'd2);
    chk("bp_valid_drop", W'(resp_valid), '0);
    tick();
    req_valid = 2'b00;
    tick();
    chk("bp_xor_valid", W'(resp_valid), 64'd2);
    chk("bp_xor_out",   resp_out,       64'hFF);
    resp_ready = 2'b10;
    tick();
    resp_ready = 2'b00;
    chk("bp_xor_done", W'(resp_valid), '0);

    // Reset during EXEC of a MUL: outputs clear at once, no response ever.
    set_req(0, ALU_MUL, 64'd6, 64'd7);
    req_valid = 2'b01;
    #1;
    chk("rst_mid_req_ready", W'(req_ready), 64'd1);
    tick();
    req_valid = 2'b00;
    tick();
    chk("rst_mid_busy", W'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("rst_mid_no_resp", W'(resp_valid), '0);
      chk("rst_mid_idle",    W'(busy),       '0);
      tick();
    end

    // Normal operation after the aborted op.
    run_op("and", 1, ALU_AND, 64'd12, 64'd10, 2, 64'd8, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
